// File: rtl/vna_regs_pkg.sv
// Shared register-map constants, SPI frame widths and controller FSM encoding
// for the VNA SPI register bank; also used by the SPI slave.
package vna_regs_pkg;

  localparam int SPI_FRAME_W = 32;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_RW_W    = 1;
  localparam int SPI_DATA_W  = SPI_FRAME_W - SPI_ADDR_W - SPI_RW_W;

  localparam int NUM_CFG  = 8;
  localparam int NUM_REGS = 16;

  // Config registers (host-writable)
  localparam int REG_SWEEP_START  = 0;
  localparam int REG_SWEEP_STOP   = 1;
  localparam int REG_SWEEP_POINTS = 2;
  localparam int REG_IF_BW        = 3;
  localparam int REG_TX_POWER     = 4;
  localparam int REG_RX_GAIN      = 5;
  localparam int REG_AVG_COUNT    = 6;
  localparam int REG_CTRL         = 7;
  // Status registers (DSP-writable, host-read-only)
  localparam int REG_STATUS       = 8;
  localparam int REG_SWEEP_IDX    = 9;
  localparam int REG_ADC_PEAK     = 10;
  localparam int REG_CAL_STATE    = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPI_RD,
    ST_SPI_WR,
    ST_DSP_WR
  } ctrl_state_t;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-clk pulse in the same cycle the level is first seen high.
// Zero latency; the pulse is combinational from the level and its registered copy.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register bank arbitrated between SPI host frames and a DSP status-write port.
// SPI read data in 2 clk (3 with a DSP write in flight); dsp_req is held until dsp_gnt.
module spi_reg_ctrl #(
  parameter int ADDR_W   = vna_regs_pkg::SPI_ADDR_W,
  parameter int DATA_W   = vna_regs_pkg::SPI_DATA_W,
  parameter int NUM_CFG  = vna_regs_pkg::NUM_CFG,
  parameter int NUM_REGS = vna_regs_pkg::NUM_REGS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         spi_addr,
  input  logic                      spi_addr_ready,
  input  logic                      spi_rw,
  input  logic [DATA_W-1:0]         spi_wdata,
  input  logic                      spi_data_ready,
  output logic [DATA_W-1:0]         spi_rdata,
  input  logic                      dsp_req,
  input  logic [ADDR_W-1:0]         dsp_addr,
  input  logic [DATA_W-1:0]         dsp_wdata,
  output logic                      dsp_gnt,
  output logic [NUM_CFG*DATA_W-1:0] cfg_flat,
  output logic                      cfg_strobe,
  output logic [ADDR_W-1:0]         cfg_idx,
  output logic [7:0]                err_cnt
);

  import vna_regs_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] CFG_LIM = ADDR_W'(NUM_CFG);
  localparam logic [ADDR_W-1:0] REG_LIM = ADDR_W'(NUM_REGS);

  logic              a_ev, d_ev, rd_ev, wr_ev;
  ctrl_state_t       state_q, state_d;
  logic              pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]  spi_idx, dsp_idx;
  logic              spi_in_bank, spi_in_cfg, dsp_in_stat, err_ev;

  edge_pulse u_addr_edge (.clk(clk), .rst(rst), .level(spi_addr_ready), .pulse(a_ev));
  edge_pulse u_data_edge (.clk(clk), .rst(rst), .level(spi_data_ready), .pulse(d_ev));

  // A read frame is triggered by the address, a write frame by the data word.
  assign rd_ev = a_ev & spi_rw;
  assign wr_ev = d_ev & ~spi_rw;

  assign spi_idx     = spi_addr[IDX_W-1:0];
  assign dsp_idx     = dsp_addr[IDX_W-1:0];
  assign spi_in_bank = spi_addr < REG_LIM;
  assign spi_in_cfg  = spi_addr < CFG_LIM;
  assign dsp_in_stat = (dsp_addr >= CFG_LIM) && (dsp_addr < REG_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_rd_q <= 1'b0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q | rd_ev;
    pend_wr_d = pend_wr_q | wr_ev;
    err_ev    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_ev || pend_rd_q) begin
          state_d   = ST_SPI_RD;
          pend_rd_d = 1'b0;
        end else if (wr_ev || pend_wr_q) begin
          state_d   = ST_SPI_WR;
          pend_wr_d = 1'b0;
        end else if (dsp_req) begin
          state_d = ST_DSP_WR;
        end
      end
      ST_SPI_RD: begin
        state_d = ST_IDLE;
        err_ev  = ~spi_in_bank;
      end
      ST_SPI_WR: begin
        state_d = ST_IDLE;
        err_ev  = ~spi_in_cfg;
      end
      ST_DSP_WR: begin
        state_d = ST_IDLE;
        err_ev  = ~dsp_in_stat;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant is live during DSP_WR; the write lands on the closing edge of that cycle.
  assign dsp_gnt = (state_q == ST_DSP_WR) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_rdata  <= '0;
      cfg_strobe <= 1'b0;
      cfg_idx    <= '0;
      err_cnt    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      cfg_strobe <= 1'b0;
      unique case (state_q)
        ST_SPI_RD: spi_rdata <= spi_in_bank ? regs[spi_idx] : '0;
        ST_SPI_WR: begin
          if (spi_in_cfg) begin
            regs[spi_idx] <= spi_wdata;
            cfg_strobe    <= 1'b1;
            cfg_idx       <= spi_addr;
          end
        end
        ST_DSP_WR: if (dsp_in_stat) regs[dsp_idx] <= dsp_wdata;
        default: ;
      endcase
      if (err_ev && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
    assign cfg_flat[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a register-map model.
module tb_spi_reg_ctrl;

  localparam int OP_HW  = 0;
  localparam int OP_HR  = 1;
  localparam int OP_DSP = 2;

  logic         clk;
  logic         rst;
  logic [6:0]   spi_addr;
  logic         spi_addr_ready;
  logic         spi_rw;
  logic [23:0]  spi_wdata;
  logic         spi_data_ready;
  logic [23:0]  spi_rdata;
  logic         dsp_req;
  logic [6:0]   dsp_addr;
  logic [23:0]  dsp_wdata;
  logic         dsp_gnt;
  logic [191:0] cfg_flat;
  logic         cfg_strobe;
  logic [6:0]   cfg_idx;
  logic [7:0]   err_cnt;

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_addr_ready(spi_addr_ready), .spi_rw(spi_rw),
    .spi_wdata(spi_wdata), .spi_data_ready(spi_data_ready), .spi_rdata(spi_rdata),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata), .dsp_gnt(dsp_gnt),
    .cfg_flat(cfg_flat), .cfg_strobe(cfg_strobe), .cfg_idx(cfg_idx), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain register map plus error counter
  logic [23:0] regs_m [16];
  int          err_m;
  logic [23:0] rdata_m;
  logic [6:0]  idx_m;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) regs_m[i] = '0;
    err_m   = 0;
    rdata_m = '0;
    idx_m   = '0;
  endfunction

  function automatic void model_err();
    if (err_m < 255) err_m = err_m + 1;
  endfunction

  function automatic void model_apply(input int op, input logic [6:0] a, input logic [23:0] d);
    if (op == OP_HW) begin
      if (a < 7'd8) begin regs_m[a[3:0]] = d; idx_m = a; end
      else model_err();
    end else if (op == OP_HR) begin
      if (a < 7'd16) rdata_m = regs_m[a[3:0]];
      else begin rdata_m = '0; model_err(); end
    end else begin
      if (a >= 7'd8 && a < 7'd16) regs_m[a[3:0]] = d;
      else model_err();
    end
  endfunction

  function automatic logic [191:0] model_flat();
    logic [191:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i*24 +: 24] = regs_m[i];
    return f;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_state(input string tag);
    check({tag, ".cfg_flat"},  cfg_flat, model_flat());
    check({tag, ".cfg_idx"},   192'(cfg_idx), 192'(idx_m));
    check({tag, ".err_cnt"},   192'(err_cnt), 192'(err_m));
    check({tag, ".spi_rdata"}, 192'(spi_rdata), 192'(rdata_m));
  endtask

  // Drives one transaction and observes strobe/grant pulses over a bounded window.
  // val: cfg slice 2 clk after data_ready (host write) or spi_rdata 3 clk after addr_ready (read).
  task automatic run_op(input int op, input logic [6:0] a, input logic [23:0] d,
                        output logic [23:0] val, output int pulses, output int cyc);
    int ai;
    ai = int'(a[2:0]);
    val = '0; pulses = 0; cyc = -1;
    @(negedge clk);
    if (op == OP_HW) begin
      spi_rw = 1'b0; spi_addr = a; spi_addr_ready = 1'b1;
      @(negedge clk);
      spi_wdata = d; spi_data_ready = 1'b1;
    end else if (op == OP_HR) begin
      spi_rw = 1'b1; spi_addr = a; spi_addr_ready = 1'b1;
    end else begin
      dsp_req = 1'b1; dsp_addr = a; dsp_wdata = d;
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (cfg_strobe || dsp_gnt) begin
        pulses++;
        if (cyc < 0) cyc = c;
      end
      if (dsp_gnt) dsp_req = 1'b0;
      if (op == OP_HR && c == 1) begin spi_wdata = 24'($urandom); spi_data_ready = 1'b1; end
      if (op == OP_HW && c == 2 && a < 7'd8) val = cfg_flat[ai*24 +: 24];
      if (op == OP_HR && c == 3) val = spi_rdata;
    end
    spi_addr_ready = 1'b0; spi_data_ready = 1'b0; dsp_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          op;
    logic [6:0]  addr;
    logic [23:0] data;
    logic [23:0] exp_val;
    int          exp_pulses;
    int          exp_err;
  } vec_t;

  vec_t        tbl [18];
  logic [23:0] val;
  int          pulses, cyc, gn, gcyc, strobes;
  logic [23:0] rd_obs;

  initial begin
    rst = 1'b1; spi_addr = '0; spi_addr_ready = 1'b0; spi_rw = 1'b0; spi_wdata = '0;
    spi_data_ready = 1'b0; dsp_req = 1'b0; dsp_addr = '0; dsp_wdata = '0;
    model_reset();

    tbl[0]  = '{OP_HW,  7'd2,  24'h123456, 24'h123456, 1, 0};
    tbl[1]  = '{OP_DSP, 7'd9,  24'hABCDEF, 24'h000000, 1, 0};
    tbl[2]  = '{OP_HR,  7'd9,  24'h000000, 24'hABCDEF, 0, 0};
    tbl[3]  = '{OP_HW,  7'd10, 24'h111111, 24'h000000, 0, 1};
    tbl[4]  = '{OP_HR,  7'd20, 24'h000000, 24'h000000, 0, 2};
    tbl[5]  = '{OP_DSP, 7'd3,  24'h555555, 24'h000000, 1, 3};
    tbl[6]  = '{OP_HR,  7'd3,  24'h000000, 24'h000000, 0, 3};
    tbl[7]  = '{OP_HR,  7'd2,  24'h000000, 24'h123456, 0, 3};
    tbl[8]  = '{OP_HW,  7'd7,  24'hFEDCBA, 24'hFEDCBA, 1, 3};
    tbl[9]  = '{OP_HR,  7'd7,  24'h000000, 24'hFEDCBA, 0, 3};
    tbl[10] = '{OP_DSP, 7'd15, 24'h000001, 24'h000000, 1, 3};
    tbl[11] = '{OP_HR,  7'd15, 24'h000000, 24'h000001, 0, 3};
    tbl[12] = '{OP_HR,  7'd16, 24'h000000, 24'h000000, 0, 4};
    tbl[13] = '{OP_DSP, 7'd16, 24'h777777, 24'h000000, 1, 5};
    tbl[14] = '{OP_HW,  7'd8,  24'h222222, 24'h000000, 0, 6};
    tbl[15] = '{OP_HR,  7'd8,  24'h000000, 24'h000000, 0, 6};
    tbl[16] = '{OP_DSP, 7'd8,  24'h333333, 24'h000000, 1, 6};
    tbl[17] = '{OP_HR,  7'd8,  24'h000000, 24'h333333, 0, 6};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compare_state("reset");
    check("reset.cfg_strobe", 192'(cfg_strobe), 192'(0));
    check("reset.dsp_gnt",    192'(dsp_gnt),    192'(0));

    for (int i = 0; i < 18; i++) begin
      run_op(tbl[i].op, tbl[i].addr, tbl[i].data, val, pulses, cyc);
      model_apply(tbl[i].op, tbl[i].addr, tbl[i].data);
      if (tbl[i].op == OP_HR || (tbl[i].op == OP_HW && tbl[i].addr < 7'd8))
        check($sformatf("tbl%0d.val", i), 192'(val), 192'(tbl[i].exp_val));
      check($sformatf("tbl%0d.pulses", i), 192'(pulses), 192'(tbl[i].exp_pulses));
      if (tbl[i].exp_pulses == 1)
        check($sformatf("tbl%0d.pulse_cyc", i), 192'(cyc), 192'(tbl[i].op == OP_HW ? 2 : 1));
      check($sformatf("tbl%0d.err_cnt", i), 192'(err_cnt), 192'(tbl[i].exp_err));
      compare_state($sformatf("tbl%0d", i));
    end

    // SPI address edge and DSP request in the same cycle: read first, grant 2 clk late
    @(negedge clk);
    spi_rw = 1'b1; spi_addr = 7'd9; spi_addr_ready = 1'b1;
    dsp_req = 1'b1; dsp_addr = 7'd12; dsp_wdata = 24'h0C0FFE;
    gn = 0; gcyc = -1; rd_obs = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (dsp_gnt) begin gn++; if (gcyc < 0) gcyc = c; dsp_req = 1'b0; end
      if (c == 3) rd_obs = spi_rdata;
    end
    spi_addr_ready = 1'b0; dsp_req = 1'b0;
    @(negedge clk);
    model_apply(OP_HR, 7'd9, '0);
    model_apply(OP_DSP, 7'd12, 24'h0C0FFE);
    check("contend.rdata", 192'(rd_obs), 192'(24'hABCDEF));
    check("contend.gnt_count", 192'(gn), 192'(1));
    check("contend.gnt_cyc", 192'(gcyc), 192'(3));
    run_op(OP_HR, 7'd12, '0, val, pulses, cyc);
    model_apply(OP_HR, 7'd12, '0);
    check("contend.readback", 192'(val), 192'(24'h0C0FFE));
    compare_state("contend");

    // Read arrives while a DSP write is in flight: pending flag, data within 3 clk
    @(negedge clk);
    dsp_req = 1'b1; dsp_addr = 7'd13; dsp_wdata = 24'h5A5A5A;
    @(negedge clk);
    check("inflight.gnt", 192'(dsp_gnt), 192'(1));
    dsp_req = 1'b0;
    spi_rw = 1'b1; spi_addr = 7'd13; spi_addr_ready = 1'b1;
    gn = 0; rd_obs = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (dsp_gnt) gn++;
      if (c == 3) rd_obs = spi_rdata;
    end
    spi_addr_ready = 1'b0;
    @(negedge clk);
    model_apply(OP_DSP, 7'd13, 24'h5A5A5A);
    model_apply(OP_HR, 7'd13, '0);
    check("inflight.rdata_3clk", 192'(rd_obs), 192'(24'h5A5A5A));
    check("inflight.extra_gnt", 192'(gn), 192'(0));
    compare_state("inflight");

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      int          op;
      logic [6:0]  a;
      logic [23:0] d;
      int          exp_p;
      op = int'($urandom_range(0, 2));
      a  = 7'($urandom_range(0, 31));
      d  = 24'($urandom);
      run_op(op, a, d, val, pulses, cyc);
      model_apply(op, a, d);
      exp_p = ((op == OP_HW && a < 7'd8) || op == OP_DSP) ? 1 : 0;
      check($sformatf("rnd%0d.pulses", i), 192'(pulses), 192'(exp_p));
      if (op == OP_HW && a < 7'd8) check($sformatf("rnd%0d.wval", i), 192'(val), 192'(d));
      if (op == OP_HR) check($sformatf("rnd%0d.rval", i), 192'(val), 192'(rdata_m));
      compare_state($sformatf("rnd%0d", i));
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      logic [6:0] a;
      a = 7'($urandom_range(16, 127));
      run_op(OP_HR, a, '0, val, pulses, cyc);
      model_apply(OP_HR, a, '0);
    end
    check("err_sat", 192'(err_cnt), 192'(8'd255));
    compare_state("sat");

    // Reset asserted while in SPI_WR
    @(negedge clk);
    spi_rw = 1'b0; spi_addr = 7'd5; spi_addr_ready = 1'b1;
    @(negedge clk);
    spi_wdata = 24'h0BEEF0; spi_data_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    compare_state("midrst");
    check("midrst.cfg_strobe", 192'(cfg_strobe), 192'(0));
    check("midrst.dsp_gnt",    192'(dsp_gnt),    192'(0));
    spi_addr_ready = 1'b0; spi_data_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    repeat (4) begin
      @(negedge clk);
      if (cfg_strobe) strobes++;
    end
    check("midrst.no_strobe", 192'(strobes), 192'(0));
    compare_state("postrst");

    run_op(OP_HW, 7'd1, 24'h13579B, val, pulses, cyc);
    model_apply(OP_HW, 7'd1, 24'h13579B);
    check("postrst.write", 192'(val), 192'(24'h13579B));
    check("postrst.strobe", 192'(pulses), 192'(1));
    compare_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-bank controller between `soft_spi_slave` and the VNA DSP datapath. It owns a bank of `NUM_REGS` × `DATA_W` registers and arbitrates the bank between two requesters: SPI host transactions and an internal DSP status port. It answers SPI reads inside the serial-latency budget. It drives configuration registers onto a flat bus and strobes the DSP on every config change.

## Interface
- `ADDR_W`, 7: SPI address width.
- `DATA_W`, 24: register/data width (32-bit frame minus 7 address bits minus 1 R/W bit).
- `NUM_CFG`, 8: config registers, addresses 0..NUM_CFG-1, host-writable.
- `NUM_REGS`, 16: total registers. NUM_CFG..NUM_REGS-1 are status registers, DSP-writable and host-read-only.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  system clock, at least 4× SCK.
- `rst`  in  1  synchronous active-high reset.
- `spi_addr`  in  ADDR_W  address from SPI slave.
- `spi_addr_ready`  in  1  level, high once the address is valid, until frame end.
- `spi_rw`  in  1  1 = host read, 0 = host write.
- `spi_wdata`  in  DATA_W  received data word.
- `spi_data_ready`  in  1  level, high once the data word is valid, until frame end.
- `spi_rdata`  out  DATA_W  read data to the SPI slave `data_in`.
- `dsp_req`  in  1  DSP status-write request, held until granted.
- `dsp_addr`  in  ADDR_W  DSP target address.
- `dsp_wdata`  in  DATA_W  DSP write data.
- `dsp_gnt`  out  1  one-cycle grant pulse; the write is committed in that cycle.
- `cfg_flat`  out  NUM_CFG*DATA_W  config registers; reg i is at bits [i*DATA_W +: DATA_W].
- `cfg_strobe`  out  1  one-cycle pulse after any config register write.
- `cfg_idx`  out  ADDR_W  index of the last written config register.
- `err_cnt`  out  8  saturating count of rejected accesses.

## Operation
- Edge detectors on `spi_addr_ready` and `spi_data_ready` produce one-cycle events `a_ev` and `d_ev`.
- FSM states:
  - IDLE: `a_ev` & `spi_rw` → SPI_RD. `d_ev` & !`spi_rw` → SPI_WR. Else `dsp_req` → DSP_WR.
  - SPI_RD: latch `spi_rdata` ← reg[spi_addr], or 0 if addr ≥ NUM_REGS (err_cnt+1). → IDLE.
  - SPI_WR:
    - addr < NUM_CFG: write the register, pulse `cfg_strobe`, set `cfg_idx`.
    - Otherwise: no write, err_cnt+1.
    - → IDLE.
  - DSP_WR:
    - NUM_CFG ≤ dsp_addr < NUM_REGS: write the register, pulse `dsp_gnt`.
    - Otherwise: pulse `dsp_gnt`, no write, err_cnt+1.
    - → IDLE.
- Priority: SPI events over DSP. A pending SPI event arriving while in DSP_WR is captured in a one-deep pending flag and serviced on the next IDLE cycle; it is never lost.
- `spi_rdata` holds its value until the next SPI_RD.
- `err_cnt` saturates at 255 and is cleared only by `rst`.
- A host write to a status address is rejected. A DSP write to a config address is rejected.

## Timing
- Reset values:
  - `spi_rdata`, `cfg_flat`, `cfg_idx`, `err_cnt` = 0.
  - `cfg_strobe`, `dsp_gnt` = 0.
  - FSM = IDLE; all registers = 0.
- SPI read latency: `spi_rdata` is valid ≤ 3 clk after `spi_addr_ready` rises, worst case with a DSP_WR in flight. This meets the slave's one-SCK budget at clk ≥ 4× SCK.
- SPI write: the register updates, and `cfg_strobe` pulses, 2 clk after `spi_data_ready` rises.
- DSP write: `dsp_gnt` asserts ≥ 1 clk after `dsp_req`. Worst case is 3 clk under continuous SPI traffic, since SPI events are sparse (≥ 8 SCK apart).
- `dsp_req` must be held with stable addr/data until `dsp_gnt`. `dsp_req` re-sampled high in the cycle after `gnt` is a new request.
- Simultaneous `a_ev` and `dsp_req` in IDLE: SPI wins, DSP is granted 2 clk later.
- `rst` asserted mid-transaction: return to IDLE next clk, drop any pending flag, no `gnt` or `strobe` issued.

## Structure
- Shared package `vna_regs_pkg`:
  - `NUM_CFG` and `NUM_REGS`.
  - Register index constants (e.g. `REG_SWEEP_START`, `REG_STATUS`).
  - FSM state enum.
  - The 32/7/1 frame-width constants shared with the SPI slave.
- One sub-module `edge_pulse`: rising-edge to one-clk pulse, instantiated twice.

## Test plan
- Host write 0x123456 to addr 2 → `cfg_flat`[71:48] = 0x123456 two clk later, one `cfg_strobe`, `cfg_idx` = 2.
- DSP writes 0xABCDEF to addr 9, then host reads addr 9 → `dsp_gnt` one pulse; `spi_rdata` = 0xABCDEF ≤ 3 clk after `spi_addr_ready`.
- `dsp_req` rises in the same cycle as the `spi_addr_ready` edge → SPI_RD serviced first, `dsp_gnt` 2 clk later, both values correct.
- Host write to addr 10 and host read of addr 20 → no register change, read returns 0, `err_cnt` = 2. After 300 such accesses, `err_cnt` = 255.
- DSP write to addr 3 → `dsp_gnt` pulses, `cfg_flat` unchanged, no `cfg_strobe`, `err_cnt` +1.
- `rst` pulsed during SPI_WR → all outputs at reset values next clk, no `cfg_strobe`.
